ex_mem_stage: RTL and testbench
===============================

EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter DATA_W, 32, width of ALU result path (signed).
REQ-002 Parameter INSTR_W, 32, width of instruction path.
REQ-003 Parameter HALT_WORD, all-ones of INSTR_W, instruction value that terminates execution.
REQ-004 Parameter CNT_W, 16, width of retired-instruction counter.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset: port CLOCK, input, 1, rising-edge clock.
REQ-006 The block SHALL have port RESET, input, 1, synchronous active-high reset.
REQ-007 The block SHALL have port FLUSH, input, 1, discard all buffered entries this cycle.
REQ-008 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_aluout (input, DATA_W, signed), in_instr (input, INSTR_W), forming the upstream valid/ready interface.
REQ-009 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_aluout (output, DATA_W, signed), out_instr (output, INSTR_W), forming the downstream valid/ready interface.
REQ-010 The block SHALL have port ff, output, 1, sticky halt flag.
REQ-011 The block SHALL have port retire_cnt, output, CNT_W, count of downstream transfers.

Function
REQ-012 Storage SHALL be a 2-entry skid buffer (main + skid), each entry holding {aluout, instr}, all outputs registered.
REQ-013 Upstream transfer occurs when in_valid & in_ready; downstream transfer when out_valid & out_ready.
REQ-014 in_ready SHALL be 1 iff skid entry empty, ff = 0, and RESET = 0.
REQ-015 Latency SHALL be 1 cycle: data accepted at edge N appears on out_* after edge N when main was empty or draining.
REQ-016 Sustained throughput SHALL be 1 transfer/cycle with out_ready held high; no bubbles.
REQ-017 When out_ready = 0 and main full, an accepted word SHALL go to skid; in_ready drops the following cycle.
REQ-018 When skid full and downstream transfer occurs, skid SHALL move to main the same edge; order strictly FIFO.
REQ-019 out_aluout/out_instr SHALL hold stable while out_valid = 1 and out_ready = 0.
REQ-020 FLUSH = 1 SHALL empty both entries at the edge, ignore any upstream word that cycle, and not increment retire_cnt; ff unaffected.
REQ-021 An accepted word with in_instr == HALT_WORD SHALL set ff at the same edge (visible next cycle); ff stays 1 until RESET.
REQ-022 The halt word itself SHALL propagate downstream normally; words already buffered continue to drain after ff = 1.
REQ-023 FLUSH and a halt-word upstream handshake in the same cycle: FLUSH wins, word dropped, ff not set.
REQ-024 retire_cnt SHALL increment by 1 per downstream transfer and saturate at 2^CNT_W-1 (no wrap).
REQ-025 ALU data SHALL pass unmodified bit-for-bit; no sign extension or arithmetic.

Reset
REQ-026 At a rising edge with RESET = 1: both entries empty, out_valid = 0, ff = 0, retire_cnt = 0, out_aluout = 0, out_instr = 0; RESET overrides FLUSH and in_valid.
REQ-027 RESET mid-stream SHALL discard buffered words; no transfer is counted that cycle.

Verification
REQ-028 Streaming: out_ready = 1, push aluout = -5, 7, 100 on consecutive cycles -> out_aluout = -5, 7, 100 one cycle later each, retire_cnt = 3, in_ready never 0.
REQ-029 Backpressure: out_ready = 0, push A, B -> in_ready = 0 after B; raise out_ready -> A then B delivered in order, in_ready returns 1.
REQ-030 Halt: push instr 0x00000013 then 0xFFFFFFFF -> ff = 1 the cycle after halt accepted, in_ready = 0 thereafter, halt word appears on out_instr, retire_cnt = 2.
REQ-031 Flush: two entries buffered, FLUSH = 1 with in_valid = 1 -> next cycle out_valid = 0, retire_cnt unchanged; FLUSH with halt word -> ff stays 0.
REQ-032 Saturation: CNT_W = 2, five downstream transfers -> retire_cnt = 3.
REQ-033 Reset mid-operation: ff = 1, entries full, RESET = 1 one cycle -> all outputs 0, in_ready = 1 next cycle.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline register built as a two-entry skid buffer.
// The main entry drives the registered out_* bus. The skid entry catches the
// one word that can arrive while downstream is stalled. A sticky halt flag
// (ff) closes the upstream port once the halt instruction has been accepted.
// retire_cnt counts downstream transfers and saturates instead of wrapping.
module ex_mem_stage #(
    parameter int                   DATA_W    = 32,
    parameter int                   INSTR_W   = 32,
    parameter logic [INSTR_W-1:0]   HALT_WORD = {INSTR_W{1'b1}},
    parameter int                   CNT_W     = 16
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        FLUSH,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    in_aluout,
    input  logic        [INSTR_W-1:0]   in_instr,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [DATA_W-1:0]    out_aluout,
    output logic        [INSTR_W-1:0]   out_instr,
    output logic                        ff,
    output logic        [CNT_W-1:0]     retire_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Main entry: this is the visible output register.
    logic                       r_main_v;
    logic signed [DATA_W-1:0]   r_main_alu;
    logic        [INSTR_W-1:0]  r_main_ins;

    // Skid entry: holds the word caught while the main entry is stalled.
    logic                       r_skid_v;
    logic signed [DATA_W-1:0]   r_skid_alu;
    logic        [INSTR_W-1:0]  r_skid_ins;

    logic                       r_ff;
    logic        [CNT_W-1:0]    r_cnt;
    logic                       r_in_ready;

    // Next-state values.
    logic                       w_main_v_nxt;
    logic signed [DATA_W-1:0]   w_main_alu_nxt;
    logic        [INSTR_W-1:0]  w_main_ins_nxt;
    logic                       w_skid_v_nxt;
    logic signed [DATA_W-1:0]   w_skid_alu_nxt;
    logic        [INSTR_W-1:0]  w_skid_ins_nxt;
    logic                       w_ff_nxt;
    logic        [CNT_W-1:0]    w_cnt_nxt;
    logic                       w_in_ready_nxt;

    // Handshakes.
    logic                       w_up;
    logic                       w_dn;
    logic                       w_is_halt;

    // Handshake decode. in_ready carries a direct RESET term so that nothing
    // is accepted while reset is being applied.
    always_comb begin
        in_ready   = r_in_ready & ~RESET;
        out_valid  = r_main_v;
        out_aluout = r_main_alu;
        out_instr  = r_main_ins;
        ff         = r_ff;
        retire_cnt = r_cnt;
        w_up       = in_valid & in_ready;
        w_dn       = r_main_v & out_ready;
        w_is_halt  = (in_instr == HALT_WORD);
    end

    // Next-state logic for both entries, the halt flag and the retire counter.
    always_comb begin
        w_main_v_nxt   = r_main_v;
        w_main_alu_nxt = r_main_alu;
        w_main_ins_nxt = r_main_ins;
        w_skid_v_nxt   = r_skid_v;
        w_skid_alu_nxt = r_skid_alu;
        w_skid_ins_nxt = r_skid_ins;
        w_ff_nxt       = r_ff;
        w_cnt_nxt      = r_cnt;

        if (FLUSH) begin
            // Drop both entries and any incoming word. The counter and the
            // halt flag keep their values.
            w_main_v_nxt = 1'b0;
            w_skid_v_nxt = 1'b0;
        end else begin
            // Count retired words, holding at the maximum value.
            if (w_dn && (r_cnt != CNT_MAX)) begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end else begin
                w_cnt_nxt = r_cnt;
            end

            // The halt word sets the sticky flag on the edge it is accepted.
            if (w_up && w_is_halt) begin
                w_ff_nxt = 1'b1;
            end else begin
                w_ff_nxt = r_ff;
            end

            if (r_skid_v) begin
                // in_ready is low here, so there is no upstream word. Refill
                // the main entry from skid as soon as main drains.
                if (w_dn) begin
                    w_main_v_nxt   = 1'b1;
                    w_main_alu_nxt = r_skid_alu;
                    w_main_ins_nxt = r_skid_ins;
                    w_skid_v_nxt   = 1'b0;
                end else begin
                    w_main_v_nxt   = r_main_v;
                    w_skid_v_nxt   = r_skid_v;
                end
            end else if (!r_main_v || w_dn) begin
                // Main is empty or draining this cycle, so the new word
                // goes straight to the output register.
                if (w_up) begin
                    w_main_v_nxt   = 1'b1;
                    w_main_alu_nxt = in_aluout;
                    w_main_ins_nxt = in_instr;
                end else begin
                    w_main_v_nxt   = 1'b0;
                end
            end else begin
                // Main is stalled, so an accepted word goes to the skid entry.
                if (w_up) begin
                    w_skid_v_nxt   = 1'b1;
                    w_skid_alu_nxt = in_aluout;
                    w_skid_ins_nxt = in_instr;
                end else begin
                    w_skid_v_nxt   = 1'b0;
                end
            end
        end

        w_in_ready_nxt = ~w_skid_v_nxt & ~w_ff_nxt;
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_main_v   <= 1'b0;
            r_main_alu <= '0;
            r_main_ins <= '0;
            r_skid_v   <= 1'b0;
            r_skid_alu <= '0;
            r_skid_ins <= '0;
            r_ff       <= 1'b0;
            r_cnt      <= '0;
            r_in_ready <= 1'b1;
        end else begin
            r_main_v   <= w_main_v_nxt;
            r_main_alu <= w_main_alu_nxt;
            r_main_ins <= w_main_ins_nxt;
            r_skid_v   <= w_skid_v_nxt;
            r_skid_alu <= w_skid_alu_nxt;
            r_skid_ins <= w_skid_ins_nxt;
            r_ff       <= w_ff_nxt;
            r_cnt      <= w_cnt_nxt;
            r_in_ready <= w_in_ready_nxt;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Testbench for ex_mem_stage. It runs directed scenarios followed by
// randomized traffic. Every cycle is checked against a queue-based model of
// a two-deep FIFO with a sticky halt flag and saturating retire counters.
module tb_ex_mem_stage;

    logic               CLOCK = 1'b0;
    logic               RESET;
    logic               FLUSH;
    logic               in_valid;
    logic               in_ready;
    logic signed [31:0] in_aluout;
    logic        [31:0] in_instr;
    logic               out_valid;
    logic               out_ready;
    logic signed [31:0] out_aluout;
    logic        [31:0] out_instr;
    logic               ff;
    logic        [15:0] retire_cnt;

    // Second instance with a 2-bit counter, driven by the same stimulus.
    logic               s_in_ready;
    logic               s_out_valid;
    logic signed [31:0] s_out_aluout;
    logic        [31:0] s_out_instr;
    logic               s_ff;
    logic        [1:0]  s_retire_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [31:0] qa[$];
    logic [31:0] qi[$];
    bit          m_ff;
    int          m_cnt;
    bit          m_zero;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    always #5 CLOCK = ~CLOCK;

    ex_mem_stage u_dut (
        .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_aluout(in_aluout), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_aluout(out_aluout), .out_instr(out_instr),
        .ff(ff), .retire_cnt(retire_cnt)
    );

    ex_mem_stage #(.CNT_W(2)) u_sat (
        .CLOCK(CLOCK), .RESET(RESET), .FLUSH(FLUSH),
        .in_valid(in_valid), .in_ready(s_in_ready),
        .in_aluout(in_aluout), .in_instr(in_instr),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_aluout(s_out_aluout), .out_instr(s_out_instr),
        .ff(s_ff), .retire_cnt(s_retire_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check outputs against the model, then step the model.
    task automatic cycle(input bit rst, input bit fl, input bit iv,
                         input logic [31:0] alu, input logic [31:0] ins, input bit ordy);
        bit exp_rdy;
        bit up;
        bit dn;
        @(negedge CLOCK);
        RESET = rst; FLUSH = fl; in_valid = iv;
        in_aluout = alu; in_instr = ins; out_ready = ordy;
        #1;
        exp_rdy = !rst && (qa.size() < 2) && !m_ff;
        chk("in_ready",   32'(in_ready),   32'(exp_rdy));
        chk("out_valid",  32'(out_valid),  32'(qa.size() > 0));
        chk("ff",         32'(ff),         32'(m_ff));
        chk("retire_cnt", 32'(retire_cnt), 32'(m_cnt > 65535 ? 65535 : m_cnt));
        chk("sat_cnt",    32'(s_retire_cnt), 32'(m_cnt > 3 ? 3 : m_cnt));
        if (qa.size() > 0) begin
            chk("out_aluout", out_aluout, qa[0]);
            chk("out_instr",  out_instr,  qi[0]);
        end else if (m_zero) begin
            chk("rst_aluout", out_aluout, 32'h0);
            chk("rst_instr",  out_instr,  32'h0);
        end
        up = iv && exp_rdy;
        dn = (qa.size() > 0) && ordy;
        @(posedge CLOCK);
        if (rst) begin
            qa.delete(); qi.delete();
            m_ff = 1'b0; m_cnt = 0; m_zero = 1'b1;
        end else if (fl) begin
            qa.delete(); qi.delete();
        end else begin
            if (dn) begin
                void'(qa.pop_front()); void'(qi.pop_front());
                m_cnt++;
            end
            if (up) begin
                qa.push_back(alu); qi.push_back(ins);
                m_zero = 1'b0;
                if (ins == HALT) m_ff = 1'b1;
            end
        end
    endtask

    task automatic push(input logic [31:0] alu, input logic [31:0] ins, input bit ordy);
        cycle(1'b0, 1'b0, 1'b1, alu, ins, ordy);
    endtask

    task automatic idle(input bit ordy);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ordy);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; FLUSH = 1'b0; in_valid = 1'b0;
        in_aluout = 32'h0; in_instr = 32'h0; out_ready = 1'b0;
        m_ff = 1'b0; m_cnt = 0; m_zero = 1'b1;
        repeat (2) @(posedge CLOCK);

        // Reset state check, then streaming -5, 7, 100 with out_ready high.
        idle(1'b1);
        push(-32'sd5, 32'h13, 1'b1);
        push(32'sd7, 32'h13, 1'b1);
        push(32'sd100, 32'h13, 1'b1);
        idle(1'b1);
        @(negedge CLOCK);
        chk("stream_cnt", 32'(retire_cnt), 32'd3);

        // Backpressure: A, B held, then released in order.
        push(32'hAAAA_0001, 32'h1, 1'b0);
        push(32'hBBBB_0002, 32'h2, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // Halt: a normal word followed by the halt word.
        do_reset();
        push(32'h1234, 32'h0000_0013, 1'b1);
        push(32'h5678, HALT, 1'b1);
        idle(1'b1);
        push(32'h9, 32'h13, 1'b1);
        idle(1'b1);
        @(negedge CLOCK);
        chk("halt_ff", 32'(ff), 32'd1);
        chk("halt_cnt", 32'(retire_cnt), 32'd2);

        // Flush with both entries full and an upstream word offered.
        do_reset();
        push(32'h11, 32'h11, 1'b0);
        push(32'h22, 32'h22, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h33, 32'h33, 1'b1);
        idle(1'b1);
        // A flush coinciding with the halt word drops it and leaves ff clear.
        cycle(1'b0, 1'b1, 1'b1, 32'h44, HALT, 1'b1);
        idle(1'b1);
        @(negedge CLOCK);
        chk("flush_halt_ff", 32'(ff), 32'd0);

        // Saturation of the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 6; i++) push(32'(i * 3 - 7), 32'(i), 1'b1);
        idle(1'b1);
        idle(1'b1);
        @(negedge CLOCK);
        chk("sat_final", 32'(s_retire_cnt), 32'd3);

        // Reset mid-operation with ff set and both entries full.
        push(32'hCAFE, 32'h1, 1'b0);
        push(32'hBEEF, HALT, 1'b0);
        idle(1'b0);
        do_reset();
        idle(1'b0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom % 40) == 0, ($urandom % 16) == 0, ($urandom % 10) < 7,
                  $urandom, (($urandom % 20) == 0) ? HALT : $urandom,
                  ($urandom % 10) < 6);
        end
        idle(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
